pool2x2_stream: RTL and testbench

//   Streaming 2x2 / stride-2 signed max-pool stage. Sits directly downstream of a

---
 rtl/pool2x2_stream.sv | 73 +++++++
 tb/tb_pool2x2_stream.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a DIM x DIM raster-order map.
// Only a half-row line buffer of pairwise maxima is kept; full rows are never stored.
module pool2x2_stream #(
  parameter int DIM = 10,
  parameter int PP  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [PP:0] pxl_in,
  output logic signed [PP:0] pool_out,
  output logic               valid,
  output logic               frame_last
);
  localparam int HW  = DIM / 2;
  localparam int CW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int LBW = (HW > 1) ? $clog2(HW) : 1;

  logic [CW-1:0]      r_col, r_row;
  logic signed [PP:0] r_h;
  logic signed [PP:0] r_lb [HW];

  logic               w_col_last, w_row_last;
  logic [LBW-1:0]     w_idx;
  logic signed [PP:0] w_pair, w_win;

  function automatic logic signed [PP:0] smax(input logic signed [PP:0] a,
                                              input logic signed [PP:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_col_last = (r_col == CW'(DIM - 1));
  assign w_row_last = (r_row == CW'(DIM - 1));
  assign w_idx      = LBW'(r_col >> 1);
  assign w_pair     = smax(r_h, pxl_in);
  assign w_win      = smax(r_lb[w_idx], w_pair);

  // Counters, hold register and the registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_h        <= '0;
      pool_out   <= '0;
      valid      <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_last <= 1'b0;
      if (in_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (!r_col[0]) begin
          r_h <= pxl_in;
        end else if (r_row[0]) begin
          pool_out   <= w_win;
          valid      <= 1'b1;
          frame_last <= w_col_last && w_row_last;
        end
      end
    end
  end

  // Line buffer holds max of each horizontal pair from the even row; no reset needed.
  always_ff @(posedge clk) begin
    if (in_valid && r_col[0] && !r_row[0])
      r_lb[w_idx] <= w_pair;
  end
endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream: DIM=4 and DIM=10 instances against a
// window-max reference computed directly from the stored frame.
module tb_pool2x2_stream;
  logic              clk = 1'b0;
  logic              reset;
  logic              iv4, iv10;
  logic signed [8:0] px4, px10;
  logic signed [8:0] pool4, pool10;
  logic              v4, v10, fl4, fl10;

  int checks = 0;
  int failures = 0;
  int fr [0:99];
  logic signed [8:0] last4, last10;

  always #5 clk = ~clk;

  pool2x2_stream #(.DIM(4), .PP(8)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .pxl_in(px4),
    .pool_out(pool4), .valid(v4), .frame_last(fl4));

  pool2x2_stream #(.DIM(10), .PP(8)) u_dut10 (
    .clk(clk), .reset(reset), .in_valid(iv10), .pxl_in(px10),
    .pool_out(pool10), .valid(v10), .frame_last(fl10));

  task automatic chk_out(input int sel, input bit ev, input logic signed [8:0] ep,
                         input bit el, input string tag);
    logic              ov, ol;
    logic signed [8:0] op, want_p;
    ov = (sel == 0) ? v4 : v10;
    ol = (sel == 0) ? fl4 : fl10;
    op = (sel == 0) ? pool4 : pool10;
    want_p = ev ? ep : ((sel == 0) ? last4 : last10);
    checks++;
    assert (ov === ev) else begin
      failures++;
      $error("FAIL %s valid got=%0b exp=%0b", tag, ov, ev);
    end
    checks++;
    assert (ol === el) else begin
      failures++;
      $error("FAIL %s frame_last got=%0b exp=%0b", tag, ol, el);
    end
    checks++;
    assert (op === want_p) else begin
      failures++;
      $error("FAIL %s pool_out got=%0d exp=%0d", tag, op, want_p);
    end
    if (ev) begin
      if (sel == 0) last4 = ep; else last10 = ep;
    end
  endtask

  // Drive one cycle at a negedge, then check the outputs one clock later.
  task automatic drv(input int sel, input bit iv, input int px, input bit ev,
                     input int ep, input bit el, input string tag);
    logic signed [8:0] p;
    p = px[8:0];
    if (sel == 0) begin iv4 = iv; px4 = p; end
    else          begin iv10 = iv; px10 = p; end
    @(negedge clk);
    iv4 = 1'b0;
    iv10 = 1'b0;
    p = ep[8:0];
    chk_out(sel, ev, p, el, tag);
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic run_frame(input int sel, input int dim, input int nbeats,
                           input bit gaps, input string tag);
    int r, c, g;
    for (int k = 0; k < nbeats; k++) begin
      r = k / dim;
      c = k % dim;
      if (gaps) begin
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) drv(sel, 1'b0, 0, 1'b0, 0, 1'b0, {tag, "_gap"});
      end
      if ((r % 2 == 1) && (c % 2 == 1))
        drv(sel, 1'b1, fr[k], 1'b1,
            max4(fr[k - dim - 1], fr[k - dim], fr[k - 1], fr[k]),
            (r == dim - 1) && (c == dim - 1), tag);
      else
        drv(sel, 1'b1, fr[k], 1'b0, 0, 1'b0, tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    iv4 = 1'b0; iv10 = 1'b0; px4 = '0; px10 = '0;
    last4 = '0; last10 = '0;
    @(negedge clk);
    @(negedge clk);
    chk_out(0, 1'b0, 9'sd0, 1'b0, "reset4");
    chk_out(1, 1'b0, 9'sd0, 1'b0, "reset10");
    reset = 1'b0;
    @(negedge clk);

    // Raster 0..15
    for (int i = 0; i < 16; i++) fr[i] = i;
    run_frame(0, 4, 16, 1'b0, "ramp");

    // All negative: signed compare
    for (int i = 0; i < 16; i++) fr[i] = i - 16;
    run_frame(0, 4, 16, 1'b0, "neg");

    // Ramp with random input gaps
    for (int i = 0; i < 16; i++) fr[i] = i;
    run_frame(0, 4, 16, 1'b1, "gaps");

    // Back-to-back frames, no gap
    run_frame(0, 4, 16, 1'b0, "b2b_a");
    for (int i = 0; i < 16; i++) fr[i] = i + 100;
    run_frame(0, 4, 16, 1'b0, "b2b_b");

    // Partial frame then reset mid-frame
    for (int i = 0; i < 16; i++) fr[i] = 200 - i;
    run_frame(0, 4, 6, 1'b0, "partial");
    reset = 1'b1;
    #1;
    last4 = '0;
    chk_out(0, 1'b0, 9'sd0, 1'b0, "in_reset_a");
    @(negedge clk);
    chk_out(0, 1'b0, 9'sd0, 1'b0, "in_reset_b");
    reset = 1'b0;
    for (int i = 0; i < 16; i++) fr[i] = i;
    run_frame(0, 4, 16, 1'b0, "post_reset");

    // DIM=10 random signed frames, one with gaps
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 100; i++) fr[i] = int'($urandom_range(0, 511)) - 256;
      run_frame(1, 10, 100, n == 1, "rand10");
    end

    // Idle tail: no spurious pulses, outputs hold
    for (int j = 0; j < 3; j++) drv(0, 1'b0, 0, 1'b0, 0, 1'b0, "idle4");
    for (int j = 0; j < 3; j++) drv(1, 1'b0, 0, 1'b0, 0, 1'b0, "idle10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
